// File: rtl/led_arb_pkg.sv
// led_arb_pkg: register map, FSM encoding and bit positions for the LED ownership arbiter
package led_arb_pkg;
    localparam logic [2:0] A_CTRL      = 3'd0;
    localparam logic [2:0] A_STATUS    = 3'd1;
    localparam logic [2:0] A_LED_VAL   = 3'd2;
    localparam logic [2:0] A_LEASE     = 3'd3;
    localparam logic [2:0] A_LEASE_CNT = 3'd4;
    localparam logic [2:0] A_KICK      = 3'd5;
    localparam logic [2:0] A_IRQ_STAT  = 3'd6;
    localparam logic [2:0] A_IRQ_EN    = 3'd7;
    localparam int CTRL_REQ      = 0;
    localparam int ST_GRANTED    = 0;
    localparam int ST_PENDING    = 1;
    localparam int ST_STATE_LSB  = 2;
    localparam int ST_SW_LSB     = 8;
    localparam int IRQ_EXPIRED   = 0;
    localparam int IRQ_PREEMPTED = 1;
    typedef enum logic [1:0] {
        LOCAL    = 2'd0,
        TO_HPS   = 2'd1,
        HPS_OWN  = 2'd2,
        TO_LOCAL = 2'd3
    } arb_state_t;
endpackage

// File: rtl/led_arb_sync_debounce.sv
// led_arb_sync_debounce: 2-flop synchronizer, with a stable-time debouncer when LED_ARB_KEY_DEBOUNCE_EN is defined
module led_arb_sync_debounce #(
    parameter int W = 1
`ifdef LED_ARB_KEY_DEBOUNCE_EN
    , parameter bit DB_EN = 1'b0,
    parameter int DB_CYC = 1000000
`endif
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta, sync;
    // two-stage metastability filter
    always_ff @(posedge clk or posedge reset)
        if (reset) {sync, meta} <= '0;
        else {sync, meta} <= {meta, d};
`ifdef LED_ARB_KEY_DEBOUNCE_EN
    generate
        if (DB_EN) begin : g_db
            localparam int CW = $clog2(DB_CYC + 1);
            logic [CW-1:0] cnt;
            logic [W-1:0] stable;
            // adopt the synchronized value only after it differs for DB_CYC consecutive cycles
            always_ff @(posedge clk or posedge reset)
                if (reset) begin
                    cnt <= '0;
                    stable <= '0;
                end else if (sync == stable) cnt <= '0;
                else if (cnt == CW'(DB_CYC - 1)) begin
                    cnt <= '0;
                    stable <= sync;
                end else cnt <= cnt + 1'b1;
            assign q = stable;
        end else begin : g_nodb
            assign q = sync;
        end
    endgenerate
`else
    assign q = sync;
`endif
endmodule

// File: rtl/led_owner_arbiter.sv
// led_owner_arbiter: lease-based LED bank ownership between HPS (Avalon-MM) and local switch/heartbeat logic
// Optional key debounce is enabled by defining LED_ARB_KEY_DEBOUNCE_EN.
module led_owner_arbiter
    import led_arb_pkg::*;
#(
    parameter int LED_W        = 8,
    parameter int SW_W         = 4,
    parameter int LEASE_W      = 24,
    parameter int HB_DIV       = 25000000,
    parameter int HANDOVER_CYC = 16
`ifdef LED_ARB_KEY_DEBOUNCE_EN
    , parameter int DB_CYC     = 1000000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    input  logic [SW_W-1:0]  sw_in,
    input  logic             key_n,
    output logic [LED_W-1:0] led_out,
    output logic             irq
);
    localparam int HBW = $clog2(HB_DIV + 1);
    localparam int BLW = $clog2(HANDOVER_CYC + 1);
    arb_state_t state;
    logic [SW_W-1:0] sw_sync;
    logic key_held, req, hb, pending;
    logic [HBW-1:0] hb_cnt;
    logic [BLW-1:0] blank;
    logic [LED_W-1:0] led_val, loc;
    logic [LEASE_W-1:0] lease, lease_cnt;
    logic [1:0] irq_stat, irq_en, ev;
    logic [31:0] rd;
    logic wr_ctrl, rel, renew, kick, blank_done, unused;
    led_arb_sync_debounce #(.W(SW_W)) u_sw_sync (
        .clk(clk), .reset(reset), .d(sw_in), .q(sw_sync)
    );
    led_arb_sync_debounce #(
        .W(1)
`ifdef LED_ARB_KEY_DEBOUNCE_EN
        , .DB_EN(1'b1), .DB_CYC(DB_CYC)
`endif
    ) u_key_sync (
        .clk(clk), .reset(reset), .d(~key_n), .q(key_held)
    );
    assign unused     = ^avs_writedata;
    assign wr_ctrl    = avs_write && avs_address == A_CTRL;
    assign rel        = wr_ctrl && !avs_writedata[CTRL_REQ];
    assign renew      = wr_ctrl && avs_writedata[CTRL_REQ];
    assign kick       = avs_write && avs_address == A_KICK;
    assign blank_done = blank == BLW'(HANDOVER_CYC - 1);
    assign pending    = state == LOCAL && req && key_held;
    assign irq        = |(irq_stat & irq_en);
    // interrupt set events; a release or reload in the expiry cycle suppresses EXPIRED
    always_comb begin
        ev = '0;
        ev[IRQ_PREEMPTED] = key_held && (state == TO_HPS || (state == HPS_OWN && !rel));
        ev[IRQ_EXPIRED] = state == HPS_OWN && !rel && !key_held && !renew && !kick
                          && lease != '0 && lease_cnt == '0;
    end
    // local display: heartbeat in the MSB, synchronized switches in the LSBs
    always_comb begin
        loc = '0;
        loc[SW_W-1:0] = sw_sync;
        loc[LED_W-1] = hb;
    end
    // register read mux; unmapped bits stay zero
    always_comb begin
        rd = '0;
        case (avs_address)
            A_CTRL:      rd[CTRL_REQ] = req;
            A_STATUS: begin
                rd[ST_GRANTED] = state == HPS_OWN;
                rd[ST_PENDING] = pending;
                rd[ST_STATE_LSB +: 2] = state;
                rd[ST_SW_LSB +: SW_W] = sw_sync;
            end
            A_LED_VAL:   rd[LED_W-1:0] = led_val;
            A_LEASE:     rd[LEASE_W-1:0] = lease;
            A_LEASE_CNT: rd[LEASE_W-1:0] = lease_cnt;
            A_IRQ_STAT:  rd[1:0] = irq_stat;
            A_IRQ_EN:    rd[1:0] = irq_en;
            default:     rd = '0;
        endcase
    end
    // ownership FSM with bus registers, lease countdown and sticky interrupt status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOCAL;
            blank <= '0;
            req <= 1'b0;
            led_val <= '0;
            lease <= '0;
            lease_cnt <= '0;
            irq_stat <= '0;
            irq_en <= '0;
        end else begin
            if (wr_ctrl) req <= avs_writedata[CTRL_REQ];
            if (avs_write && avs_address == A_LED_VAL) led_val <= avs_writedata[LED_W-1:0];
            if (avs_write && avs_address == A_LEASE) lease <= avs_writedata[LEASE_W-1:0];
            if (avs_write && avs_address == A_IRQ_EN) irq_en <= avs_writedata[1:0];
            irq_stat <= (irq_stat & ~((avs_write && avs_address == A_IRQ_STAT) ? avs_writedata[1:0] : 2'b00)) | ev;
            blank <= blank + 1'b1;
            case (state)
                LOCAL:
                    if (req && !key_held) begin
                        state <= TO_HPS;
                        blank <= '0;
                    end
                TO_HPS:
                    if (!req || key_held) state <= LOCAL;
                    else if (blank_done) begin
                        state <= HPS_OWN;
                        lease_cnt <= lease;
                    end
                HPS_OWN: begin
                    if (renew || kick) lease_cnt <= lease;
                    else if (lease != '0 && lease_cnt != '0) lease_cnt <= lease_cnt - 1'b1;
                    if (rel || key_held || ev[IRQ_EXPIRED]) begin
                        state <= TO_LOCAL;
                        blank <= '0;
                    end
                    if (ev[IRQ_EXPIRED]) req <= 1'b0;
                end
                TO_LOCAL:
                    if (blank_done) state <= LOCAL;
                default: state <= LOCAL;
            endcase
        end
    end
    // heartbeat divider, free-running in every state
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            hb_cnt <= '0;
            hb <= 1'b0;
        end else if (hb_cnt == HBW'(HB_DIV - 1)) begin
            hb_cnt <= '0;
            hb <= ~hb;
        end else hb_cnt <= hb_cnt + 1'b1;
    // registered LED drive and read data
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            led_out <= '0;
            avs_readdata <= '0;
        end else begin
            led_out <= state == LOCAL ? loc : state == HPS_OWN ? led_val : '0;
            if (avs_read) avs_readdata <= rd;
        end
endmodule

// File: tb/tb_led_owner_arbiter.sv
// tb_led_owner_arbiter: directed self-checking bench with a read scoreboard for led_owner_arbiter
module tb_led_owner_arbiter;
    logic clk, reset, avs_read, avs_write, key_n, irq;
    logic [2:0] avs_address;
    logic [31:0] avs_writedata, avs_readdata;
    logic [3:0] sw_in;
    logic [7:0] led_out;
    int checks = 0;
    int fails = 0;
    int cyc;
    typedef struct {
        string tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    led_owner_arbiter #(.HB_DIV(8)) dut (
        .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .sw_in(sw_in), .key_n(key_n), .led_out(led_out), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // posedges since reset release
    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // LED value in local mode after n clock edges: heartbeat period 16, switches 4'hA
    function automatic logic [7:0] exp_local(input int n);
        return (((n - 1) / 8) % 2 != 0 ? 8'h80 : 8'h00) | 8'h0A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string tag);
        sb_t s;
        avs_address = a;
        avs_read = 1'b1;
        sbq.push_back('{tag: tag, exp: e});
        @(negedge clk);
        avs_read = 1'b0;
        s = sbq.pop_front();
        chk(s.tag, avs_readdata, s.exp);
    endtask

    initial begin
        logic [7:0] e8;
        reset = 1'b1;
        avs_address = 3'd0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = 32'd0;
        sw_in = 4'b1010;
        key_n = 1'b1;
        // 1: reset values, switch latency, heartbeat
        tick(3);
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        tick(2);
        chk("t1_sync_lat", 32'(led_out), 32'h0);
        for (int n = 3; n <= 20; n++) begin
            tick(1);
            chk("t1_local", 32'(led_out), 32'(exp_local(cyc)));
        end
        // 2: timed lease expiry
        wr(3'd3, 32'd20);
        wr(3'd2, 32'h5A);
        wr(3'd7, 32'h1);
        wr(3'd0, 32'h1);
        for (int k = 1; k <= 56; k++) begin
            tick(1);
            e8 = (k <= 1 || k >= 55) ? exp_local(cyc) : (k >= 18 && k <= 38) ? 8'h5A : 8'h00;
            chk("t2_led", 32'(led_out), 32'(e8));
            chk("t2_irq", 32'(irq), 32'(k >= 38));
        end
        rd(3'd6, 32'h1, "t2_irq_stat");
        rd(3'd1, 32'hA00, "t2_status_local");
        rd(3'd0, 32'h0, "t2_req_cleared");
        wr(3'd6, 32'h1);
        rd(3'd6, 32'h0, "t2_w1c");
        chk("t2_irq_clr", 32'(irq), 32'h0);
        // 3: periodic kicks keep the lease alive
        wr(3'd0, 32'h1);
        tick(17);
        for (int i = 0; i < 5; i++) begin
            wr(3'd5, 32'h0);
            tick(4);
            rd(3'd4, 32'd16, "t3_lease_cnt");
            tick(4);
        end
        rd(3'd1, 32'hA09, "t3_status_owned");
        rd(3'd6, 32'h0, "t3_no_expiry");
        chk("t3_led", 32'(led_out), 32'h5A);
        wr(3'd0, 32'h0);
        tick(20);
        // 4: key pre-emption, pending while held, regain after release
        wr(3'd0, 32'h1);
        tick(17);
        key_n = 1'b0;
        tick(25);
        rd(3'd1, 32'hA02, "t4_pending");
        rd(3'd6, 32'h2, "t4_preempted");
        chk("t4_irq_masked", 32'(irq), 32'h0);
        chk("t4_led_local", 32'(led_out), 32'(exp_local(cyc)));
        key_n = 1'b1;
        tick(25);
        rd(3'd1, 32'hA09, "t4_regained");
        wr(3'd0, 32'h0);
        tick(20);
        // 5: infinite lease, then release without interrupt
        wr(3'd3, 32'd0);
        wr(3'd0, 32'h1);
        tick(1000);
        rd(3'd1, 32'hA09, "t5_still_owned");
        rd(3'd4, 32'h0, "t5_lease_cnt");
        wr(3'd0, 32'h0);
        rd(3'd1, 32'hA0C, "t5_to_local");
        chk("t5_irq", 32'(irq), 32'h0);
        rd(3'd6, 32'h2, "t5_irq_stat");
        tick(20);
        // 6a: release in the same cycle as expiry
        wr(3'd3, 32'd20);
        wr(3'd0, 32'h1);
        tick(37);
        chk("t6_led_last", 32'(led_out), 32'h5A);
        wr(3'd0, 32'h0);
        rd(3'd6, 32'h2, "t6_no_expired");
        rd(3'd1, 32'hA0C, "t6_to_local");
        tick(20);
        // 6b: reset during TO_HPS
        wr(3'd0, 32'h1);
        tick(5);
        rd(3'd2, 32'h5A, "t6_led_val");
        reset = 1'b1;
        tick(1);
        chk("t6_rst_led", 32'(led_out), 32'h0);
        chk("t6_rst_rdata", avs_readdata, 32'h0);
        chk("t6_rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        rd(3'd1, 32'h0, "t6_status");
        rd(3'd0, 32'h0, "t6_ctrl");
        rd(3'd2, 32'h0, "t6_ledval");
        rd(3'd3, 32'h0, "t6_lease");
        rd(3'd4, 32'h0, "t6_lease_cnt");
        rd(3'd6, 32'h0, "t6_irq_stat");
        rd(3'd7, 32'h0, "t6_irq_en");
        chk("t6_led_local", 32'(led_out), 32'(exp_local(cyc)));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
